sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer: the receive end of the team's MSB-first parallel-to-serial shift-register link. It captures one serial bit per enabled clock, frames bits into WIDTH-bit words aligned by a start marker, and presents each completed word on a registered valid/ready output port. A sticky flag records any word lost to output back-pressure.

---
 rtl/sipo_deser.sv | 99 +++++++++
 tb/tb_sipo_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser
//   Serial-in, parallel-out deserializer: receive end of the MSB-first
//   shift-register link. One serial bit is captured per enabled clock,
//   bits are framed into WIDTH-bit words by a start marker, and each
//   completed word is presented on a registered valid/ready output port.
//   A sticky flag records any word lost to output back-pressure.
//
// Ports
//   clk          rising-edge clock, single domain
//   rst          synchronous active-high reset
//   shift_en     serial_in carries a valid bit this cycle
//   frame_start  (qualified by shift_en) current bit is the MSB of a new word
//   serial_in    serial data bit, MSB first
//   parallel_out last completed word (registered)
//   out_valid    parallel_out holds an unconsumed word
//   out_ready    consumer accepts the word
//   overrun      sticky: a completed word was dropped
//   state_dbg    FSM state (0 = IDLE, 1 = RECV) for checkers
//
// Handshake: a word transfers on any clk edge where out_valid && out_ready.
//   out_valid, once set, stays set until that transfer; parallel_out is
//   stable while out_valid is high unless a new word replaces it in the very
//   cycle the old one is accepted. out_ready has no combinational path to
//   any output.

module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             frame_start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             state_dbg
);

  // Enough bits to hold WIDTH-1 (WIDTH >= 2 gives at least one bit).
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sh;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  word;
  logic              last_bit;

  // Word formed if the current bit completes it.
  assign word      = {sh[WIDTH-2:0], serial_in};
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sh           <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // Consumption; overridden below if a new word lands this same edge.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (shift_en) begin
        if (frame_start) begin
          // New word from either state; any partial word is dropped silently.
          sh    <= {{(WIDTH-1){1'b0}}, serial_in};
          cnt   <= CW'(1);
          state <= RECV;
        end else if (state == RECV) begin
          sh <= word;
          if (last_bit) begin
            // Stay in RECV so the next word streams without a new marker.
            cnt <= '0;
            if (!out_valid || out_ready) begin
              parallel_out <= word;
              out_valid    <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser
//   Directed bench for sipo_deser (WIDTH=4 main instance, WIDTH=2 boundary
//   instance sharing the same stimulus).

module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       shift_en;
  logic       frame_start;
  logic       serial_in;
  logic       out_ready;
  logic [3:0] parallel_out;
  logic       out_valid;
  logic       overrun;
  logic       state_dbg;
  logic [1:0] parallel_out2;
  logic       out_valid2;
  logic       overrun2;
  logic       state_dbg2;

  int vectors;
  int miscompares;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sipo_deser #(.WIDTH(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .frame_start  (frame_start),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  sipo_deser #(.WIDTH(2)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (shift_en),
    .frame_start  (frame_start),
    .serial_in    (serial_in),
    .parallel_out (parallel_out2),
    .out_valid    (out_valid2),
    .out_ready    (out_ready),
    .overrun      (overrun2),
    .state_dbg    (state_dbg2)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic fs, input logic b);
    shift_en    = 1'b1;
    frame_start = fs;
    serial_in   = b;
    tick();
    shift_en    = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
  endtask

  // Framed 4-bit word, MSB first.
  task automatic send_word(input logic fs, input logic [3:0] w);
    logic [3:0] v;
    v = w;
    send_bit(fs, v[3]);
    send_bit(1'b0, v[2]);
    send_bit(1'b0, v[1]);
    send_bit(1'b0, v[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] po, input logic v, input logic ov);
    check({tag, ".parallel_out"}, 32'(parallel_out), 32'(po));
    check({tag, ".out_valid"},    32'(out_valid),    32'(v));
    check({tag, ".overrun"},      32'(overrun),      32'(ov));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    shift_en    = 1'b0;
    frame_start = 1'b0;
    serial_in   = 1'b0;
    out_ready   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_out("reset", 4'h0, 1'b0, 1'b0);
    check("reset.state", 32'(state_dbg), 32'd0);
    check("reset.w2_valid", 32'(out_valid2), 32'd0);

    // Basic word 1011; WIDTH=2 instance sees words 10 and 11.
    send_bit(1'b1, 1'b1);
    check("basic.state", 32'(state_dbg), 32'd1);
    send_bit(1'b0, 1'b0);
    check("w2.first_word", 32'(parallel_out2), 32'h2);
    check("w2.first_valid", 32'(out_valid2), 32'd1);
    check("basic.mid_valid", 32'(out_valid), 32'd0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check_out("basic", 4'hB, 1'b1, 1'b0);
    check("w2.second_word", 32'(parallel_out2), 32'h3);
    check("w2.overrun", 32'(overrun2), 32'd0);
    tick();
    check_out("basic.consumed", 4'hB, 1'b0, 1'b0);

    // Streaming C then 6, second word has a 2-cycle gap mid-word.
    send_word(1'b1, 4'hC);
    check_out("stream.c", 4'hC, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    tick();
    tick();
    check_out("stream.gap", 4'hC, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check_out("stream.6", 4'h6, 1'b1, 1'b0);
    tick();

    // Resync: two bits then a fresh frame_start with 0101.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_word(1'b1, 4'h5);
    check_out("resync", 4'h5, 1'b1, 1'b0);
    tick();
    check_out("resync.consumed", 4'h5, 1'b0, 1'b0);

    // Back-pressure: A held, 5 dropped, overrun sticky.
    out_ready = 1'b0;
    send_word(1'b1, 4'hA);
    check_out("bp.a", 4'hA, 1'b1, 1'b0);
    send_word(1'b0, 4'h5);
    check_out("bp.5_dropped", 4'hA, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    check_out("bp.drain", 4'hA, 1'b0, 1'b1);

    // Simultaneous consume and complete.
    do_reset();
    check_out("reset2", 4'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_word(1'b1, 4'h3);
    check_out("simul.3", 4'h3, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check_out("simul.hold", 4'h3, 1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    check_out("simul.9", 4'h9, 1'b1, 1'b0);
    tick();
    check_out("simul.consumed", 4'h9, 1'b0, 1'b0);

    // Reset mid-word while out_valid=1.
    out_ready = 1'b0;
    send_word(1'b1, 4'hE);
    check_out("rst.e", 4'hE, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    do_reset();
    check_out("rst.mid", 4'h0, 1'b0, 1'b0);
    check("rst.state", 32'(state_dbg), 32'd0);
    out_ready = 1'b1;
    send_word(1'b0, 4'hF);
    check_out("rst.unframed", 4'h0, 1'b0, 1'b0);
    check("rst.unframed_state", 32'(state_dbg), 32'd0);
    send_word(1'b1, 4'hF);
    check_out("rst.f", 4'hF, 1'b1, 1'b0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
